// File: rtl/reaction_round_ctrl.sv
// Session sequencer for the reaction-time tester: random foreperiod, ms timebase,
// reaction/timeout timing, option pulses to the round FSM and per-session statistics.
module reaction_round_ctrl #(
    parameter int CLK_PER_MS   = 50000,
    parameter int ROUNDS       = 4,
    parameter int MIN_WAIT_MS  = 1000,
    parameter int TIMEOUT_MS   = 2000,
    parameter int MIN_VALID_MS = 100,
    parameter int HOLD_MS      = 1500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_pulse,
    input  logic        react_pulse,
    output logic [3:0]  option,
    output logic        round_clr,
    output logic [15:0] act_time,
    output logic [15:0] best_time,
    output logic [15:0] avg_time,
    output logic [2:0]  round_idx,
    output logic [3:0]  fail_cnt,
    output logic [2:0]  phase,
    output logic        done
);

    localparam int PW        = $clog2(CLK_PER_MS);
    localparam int AVG_SHIFT = $clog2(ROUNDS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_REACT  = 3'd2,
        S_RESULT = 3'd3,
        S_FAIL   = 3'd4,
        S_DONE   = 3'd5
    } phase_t;

    phase_t        state, state_nxt;
    logic          start_r, react_r;
    logic [15:0]   lfsr;
    logic [PW-1:0] presc;
    logic [15:0]   ms_cnt;
    logic [15:0]   wait_ms;
    logic [18:0]   sum;
    logic [3:0]    rounds_done;
    logic [3:0]    rounds_inc;
    logic          tick, wait_end, hold_end, time_up, entering;
    logic [3:0]    opt_nxt;
    logic          clr_nxt, new_session, latch_wait, take_result, take_fail;

    assign tick       = (presc == PW'(CLK_PER_MS - 1));
    assign wait_end   = tick && (ms_cnt + 16'd1 == wait_ms);
    assign hold_end   = tick && (ms_cnt + 16'd1 == 16'(HOLD_MS));
    assign time_up    = tick && (act_time + 16'd1 == 16'(TIMEOUT_MS));
    assign entering   = (state_nxt != state);
    assign rounds_inc = rounds_done + 4'd1;
    assign phase      = state;

    // React is tested before the tick so a simultaneous press beats the timeout.
    always_comb begin
        state_nxt   = state;
        opt_nxt     = 4'b0000;
        clr_nxt     = 1'b0;
        new_session = 1'b0;
        latch_wait  = 1'b0;
        take_result = 1'b0;
        take_fail   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_r) begin
                    opt_nxt     = 4'b1000;
                    clr_nxt     = 1'b1;
                    new_session = 1'b1;
                    latch_wait  = 1'b1;
                    state_nxt   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (react_r) begin
                    opt_nxt   = 4'b0100;
                    take_fail = 1'b1;
                    state_nxt = S_FAIL;
                end else if (wait_end) begin
                    opt_nxt   = 4'b0010;
                    state_nxt = S_REACT;
                end
            end
            S_REACT: begin
                if (react_r) begin
                    opt_nxt = 4'b0100;
                    if (act_time >= 16'(MIN_VALID_MS)) begin
                        take_result = 1'b1;
                        state_nxt   = S_RESULT;
                    end else begin
                        take_fail = 1'b1;
                        state_nxt = S_FAIL;
                    end
                end else if (time_up) begin
                    opt_nxt   = 4'b0001;
                    take_fail = 1'b1;
                    state_nxt = S_FAIL;
                end
            end
            S_RESULT: begin
                if (hold_end) begin
                    if (rounds_done == 4'(ROUNDS)) begin
                        state_nxt = S_DONE;
                    end else begin
                        clr_nxt    = 1'b1;
                        latch_wait = 1'b1;
                        state_nxt  = S_WAIT;
                    end
                end
            end
            S_FAIL: begin
                if (hold_end) begin
                    clr_nxt    = 1'b1;
                    latch_wait = 1'b1;
                    state_nxt  = S_WAIT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            start_r     <= 1'b0;
            react_r     <= 1'b0;
            lfsr        <= 16'hACE1;
            presc       <= '0;
            ms_cnt      <= '0;
            wait_ms     <= '0;
            sum         <= '0;
            rounds_done <= '0;
            option      <= 4'b0000;
            round_clr   <= 1'b0;
            done        <= 1'b0;
            act_time    <= '0;
            best_time   <= 16'hFFFF;
            avg_time    <= '0;
            round_idx   <= '0;
            fail_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            start_r   <= start_pulse;
            react_r   <= react_pulse;
            lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            option    <= opt_nxt;
            round_clr <= clr_nxt;
            done      <= (state_nxt == S_DONE);

            // Timebase restarts on every phase entry so the first ms is a full one.
            if (entering || tick) presc <= '0;
            else                  presc <= presc + PW'(1);
            if (entering)  ms_cnt <= '0;
            else if (tick) ms_cnt <= ms_cnt + 16'd1;

            if (latch_wait) wait_ms <= 16'(MIN_WAIT_MS) + {5'd0, lfsr[10:0]};

            if (new_session || (state == S_WAIT && state_nxt == S_REACT))
                act_time <= '0;
            else if (state == S_REACT && !react_r && tick)
                act_time <= act_time + 16'd1;

            if (new_session) begin
                best_time   <= 16'hFFFF;
                sum         <= '0;
                rounds_done <= '0;
                round_idx   <= '0;
                fail_cnt    <= '0;
            end else begin
                if (take_result) begin
                    sum         <= sum + {3'd0, act_time};
                    rounds_done <= rounds_inc;
                    round_idx   <= (rounds_inc > 4'd7) ? 3'd7 : rounds_inc[2:0];
                    if (act_time < best_time) best_time <= act_time;
                end
                if (take_fail && fail_cnt != 4'hF) fail_cnt <= fail_cnt + 4'd1;
            end

            if (state == S_RESULT && state_nxt == S_DONE)
                avg_time <= 16'(sum >> AVG_SHIFT);
        end
    end

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Bench for reaction_round_ctrl: directed session table, hand corner cases and
// random attempts scored against a session-level model.
module tb_reaction_round_ctrl;

    localparam int CPM  = 4;
    localparam int MINW = 10;
    localparam int TMO  = 50;
    localparam int MINV = 5;
    localparam int HOLD = 3;
    localparam int RND  = 2;

    localparam int K_START = 0;
    localparam int K_EARLY = 1;
    localparam int K_REACT = 2;
    localparam int K_TMO   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_pulse = 1'b0;
    logic        react_pulse = 1'b0;
    logic [3:0]  option;
    logic        round_clr;
    logic [15:0] act_time, best_time, avg_time;
    logic [2:0]  round_idx;
    logic [3:0]  fail_cnt;
    logic [2:0]  phase;
    logic        done;

    reaction_round_ctrl #(
        .CLK_PER_MS(CPM), .ROUNDS(RND), .MIN_WAIT_MS(MINW),
        .TIMEOUT_MS(TMO), .MIN_VALID_MS(MINV), .HOLD_MS(HOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_pulse(start_pulse), .react_pulse(react_pulse),
        .option(option), .round_clr(round_clr), .act_time(act_time),
        .best_time(best_time), .avg_time(avg_time), .round_idx(round_idx),
        .fail_cnt(fail_cnt), .phase(phase), .done(done)
    );

    always #5 clk = ~clk;

    // Reference LFSR from its definition: Fibonacci, taps 16,14,13,11, seed ACE1.
    logic [15:0] ref_lfsr;
    always @(posedge clk) begin
        if (!rst_n) ref_lfsr <= 16'hACE1;
        else        ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
    end

    int n_tests = 0;
    int n_fail  = 0;
    int w;
    int m_rounds, m_fails, m_sum, m_best, m_act;

    typedef struct {
        int kind; int a; int off; int eopt; int eph; int eact; int eavg;
    } vec_t;
    vec_t tbl [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_phase"}, int'(phase), 0);
        chk({tag, "_option"}, int'(option), 0);
        chk({tag, "_round_clr"}, int'(round_clr), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_act"}, int'(act_time), 0);
        chk({tag, "_avg"}, int'(avg_time), 0);
        chk({tag, "_best"}, int'(best_time), 16'hFFFF);
        chk({tag, "_round_idx"}, int'(round_idx), 0);
        chk({tag, "_fail_cnt"}, int'(fail_cnt), 0);
    endtask

    task automatic do_start(input int eopt, input int eph);
        start_pulse = 1'b1;
        step();
        w = MINW + int'(ref_lfsr[10:0]);
        start_pulse = 1'b0;
        step();
        chk("start_option", int'(option), eopt);
        chk("start_round_clr", int'(round_clr), 1);
        chk("start_phase", int'(phase), eph);
        chk("start_best", int'(best_time), 16'hFFFF);
        chk("start_round_idx", int'(round_idx), 0);
        chk("start_fail_cnt", int'(fail_cnt), 0);
        chk("start_act", int'(act_time), 0);
        chk("start_done", int'(done), 0);
        m_rounds = 0; m_fails = 0; m_sum = 0; m_best = 65535; m_act = 0;
    endtask

    // Called right after WAIT_RAND entry; returns right after REACT entry.
    task automatic await_react();
        int n;
        n = 0;
        do begin
            step();
            n++;
            if (n == 1) chk("round_clr_width", int'(round_clr), 0);
        end while (option == 4'b0000 && n < CPM * (MINW + 2048) + 8);
        chk("foreperiod_cycles", n, w * CPM);
        chk("react_rdy_option", int'(option), 4'b0010);
        chk("react_phase", int'(phase), 2);
        chk("react_act_clear", int'(act_time), 0);
    endtask

    task automatic hold_phase(input int eavg);
        step();
        chk("outcome_option_width", int'(option), 0);
        repeat (CPM * HOLD - 2) step();
        w = MINW + int'(ref_lfsr[10:0]);
        step();
        if (m_rounds == RND) begin
            chk("done_phase", int'(phase), 5);
            chk("done_flag", int'(done), 1);
            chk("done_avg", int'(avg_time), m_sum / RND);
            chk("done_best", int'(best_time), m_best);
            chk("done_round_clr", int'(round_clr), 0);
            if (eavg >= 0) chk("done_avg_table", int'(avg_time), eavg);
        end else begin
            chk("retry_phase", int'(phase), 1);
            chk("retry_round_clr", int'(round_clr), 1);
            chk("retry_option", int'(option), 0);
            chk("retry_done", int'(done), 0);
        end
    endtask

    function automatic void model_outcome(input int kind, input int a,
                                          output int eo, output int ep, output int ea);
        if (kind == K_EARLY) begin
            eo = 4; ep = 4; ea = m_act;
        end else if (kind == K_TMO) begin
            eo = 1; ep = 4; ea = TMO;
        end else begin
            eo = 4; ep = (a >= MINV) ? 3 : 4; ea = a;
        end
    endfunction

    task automatic do_attempt(input int kind, input int a, input int off,
                              input int eopt, input int eph, input int eact, input int eavg);
        int n;
        if (kind == K_EARLY) begin
            repeat ($urandom_range(0, 30)) step();
            react_pulse = 1'b1;
            step();
            react_pulse = 1'b0;
            step();
        end else begin
            await_react();
            if (kind == K_REACT) begin
                repeat (CPM * a + off - 1) step();
                react_pulse = 1'b1;
                step();
                react_pulse = 1'b0;
                step();
            end else begin
                n = 0;
                do begin
                    step();
                    n++;
                end while (option == 4'b0000 && n < CPM * TMO + 8);
                chk("timeout_cycles", n, CPM * TMO);
            end
        end
        chk("outcome_option", int'(option), eopt);
        chk("outcome_phase", int'(phase), eph);
        chk("outcome_act", int'(act_time), eact);
        if (kind == K_REACT && a >= MINV) begin
            m_rounds++;
            m_sum += a;
            if (a < m_best) m_best = a;
        end else if (m_fails < 15) begin
            m_fails++;
        end
        if (kind == K_REACT) m_act = a;
        else if (kind == K_TMO) m_act = TMO;
        chk("outcome_fail_cnt", int'(fail_cnt), m_fails);
        chk("outcome_round_idx", int'(round_idx), m_rounds);
        chk("outcome_best", int'(best_time), m_best);
        hold_phase(eavg);
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        int eo, ep, ea, kind, a;
        tbl[0] = '{K_START, 0,  0, 8, 1, 0,  -1};
        tbl[1] = '{K_REACT, 20, 1, 4, 3, 20, -1};
        tbl[2] = '{K_REACT, 30, 0, 4, 3, 30, 25};
        tbl[3] = '{K_START, 0,  0, 8, 1, 0,  -1};
        tbl[4] = '{K_EARLY, 0,  0, 4, 4, 0,  -1};
        tbl[5] = '{K_REACT, 3,  2, 4, 4, 3,  -1};
        tbl[6] = '{K_TMO,   0,  0, 1, 4, 50, -1};
        tbl[7] = '{K_REACT, 49, 3, 4, 3, 49, -1};
        tbl[8] = '{K_REACT, 5,  0, 4, 3, 5,  27};

        repeat (3) step();
        check_reset_vals("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].kind == K_START) do_start(tbl[i].eopt, tbl[i].eph);
            else do_attempt(tbl[i].kind, tbl[i].a, tbl[i].off,
                            tbl[i].eopt, tbl[i].eph, tbl[i].eact, tbl[i].eavg);
        end
        chk("session2_fail_cnt", int'(fail_cnt), 3);

        do_start(8, 1);
        for (int i = 0; i < 4; i++) begin
            kind = int'($urandom_range(0, 9));
            kind = (kind < 2) ? K_EARLY : (kind == 2) ? K_TMO : K_REACT;
            a = int'($urandom_range(1, 49));
            model_outcome(kind, a, eo, ep, ea);
            do_attempt(kind, a, int'($urandom_range(0, 3)), eo, ep, ea, -1);
            if (m_rounds == RND) break;
        end

        if (m_rounds == RND) do_start(8, 1);
        await_react();
        repeat (7) step();
        rst_n = 1'b0;
        step();
        check_reset_vals("abort");
        rst_n = 1'b1;
        step();
        chk("abort_idle_phase", int'(phase), 0);
        chk("abort_idle_option", int'(option), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
